// File: rtl/div_pkg.sv
// Shared widths, state encoding and divide-by-zero constant for the
// sequential restoring divider.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  localparam logic [DW_DEF-1:0] DZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// compare against the divisor and conditionally subtract.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] pr_in,
  input  logic          dvd_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] pr_out,
  output logic          q_bit
);

  logic [VW:0]   t;
  logic [VW-1:0] diff;

  assign t     = {pr_in, dvd_bit};
  assign q_bit = (t >= {1'b0, divisor});
  // When t >= divisor the true difference is below divisor, so the
  // low VW bits of a VW-bit subtraction are already exact.
  assign diff   = t[VW-1:0] - divisor;
  assign pr_out = q_bit ? diff : t[VW-1:0];

endmodule

// File: rtl/seq_div_8by4.sv
// Iterative 8-by-4 unsigned restoring divider, one quotient bit per clock,
// valid/ready handshake on operands and result.
module seq_div_8by4
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] pr_reg;
  logic [VW-1:0] divisor_reg;
  logic          dz_reg;

  logic [VW-1:0] step_pr;
  logic          step_q;
  logic          last_iter;

  div_step #(.VW(VW)) u_step (
    .pr_in   (pr_reg),
    .dvd_bit (q_reg[DW-1]),
    .divisor (divisor_reg),
    .pr_out  (step_pr),
    .q_bit   (step_q)
  );

  assign last_iter = (cnt_reg == CW'(DW - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = CALC;
      // A zero divisor spends one cycle in CALC with its result already
      // loaded, giving it a one-cycle latency like a single iteration.
      CALC: if (dz_reg || last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      q_reg       <= '0;
      pr_reg      <= '0;
      divisor_reg <= '0;
      dz_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            divisor_reg <= divisor;
            cnt_reg     <= '0;
            if (divisor == '0) begin
              q_reg  <= DZ_QUOT;
              pr_reg <= dividend[VW-1:0];
              dz_reg <= 1'b1;
            end else begin
              q_reg  <= dividend;
              pr_reg <= '0;
              dz_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!dz_reg) begin
            q_reg   <= {q_reg[DW-2:0], step_q};
            pr_reg  <= step_pr;
            cnt_reg <= last_iter ? '0 : cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE) && !rst;
  assign out_valid   = (state_reg == DONE);
  assign quotient    = q_reg;
  assign remainder   = pr_reg;
  assign div_by_zero = dz_reg;

endmodule
